// File: rtl/ir_nec_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : ir_nec_decoder
//  Purpose  : Decodes NEC IR frames from the demodulated receiver pin into a
//             32-bit command word, flags repeat codes and aborted frames.
//  Ports    : clk           - system clock
//             rst_n         - asynchronous active-low reset
//             ir_rx         - raw receiver output (async, idle high, mark=low)
//             ir_command    - last accepted frame, LSB first
//                             [7:0] addr, [15:8] addr_ext, [23:16] cmd,
//                             [31:24] ~cmd
//             ir_data_ready - 1-clk pulse, ir_command updated same cycle
//             ir_repeat     - 1-clk pulse on a valid repeat frame
//             ir_error      - 1-clk pulse when a frame is aborted after its
//                             leader was accepted
//  Options  : IR_CMD_CHECK_EN - when defined, a frame is accepted only if
//             byte 3 is the complement of byte 2
//  Revision : 1.0 - initial release
// ============================================================================
module ir_nec_decoder #(
    parameter int CLK_FREQ       = 50_000_000,
    parameter int LEAD_MARK_MIN  = 7000,
    parameter int LEAD_SPACE_THR = 3375,
    parameter int BIT_SPACE_THR  = 1125,
    parameter int MARK_MIN       = 300,
    parameter int MARK_MAX       = 900,
    parameter int TIMEOUT_US     = 12000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ir_rx,
    output logic [31:0] ir_command,
    output logic        ir_data_ready,
    output logic        ir_repeat,
    output logic        ir_error
);

    localparam int c_TICKS_PER_US = (CLK_FREQ / 1_000_000 < 1) ? 1 : CLK_FREQ / 1_000_000;
    localparam int c_PRE_W        = (c_TICKS_PER_US > 1) ? $clog2(c_TICKS_PER_US) : 1;
    localparam int c_CNT_W        = $clog2(TIMEOUT_US + 2);

    localparam logic [c_PRE_W-1:0] c_PRE_LAST       = c_PRE_W'(c_TICKS_PER_US - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_SAT        = c_CNT_W'(TIMEOUT_US + 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT        = c_CNT_W'(TIMEOUT_US);
    localparam logic [c_CNT_W-1:0] c_LEAD_MARK_MIN  = c_CNT_W'(LEAD_MARK_MIN);
    localparam logic [c_CNT_W-1:0] c_LEAD_SPACE_THR = c_CNT_W'(LEAD_SPACE_THR);
    localparam logic [c_CNT_W-1:0] c_BIT_SPACE_THR  = c_CNT_W'(BIT_SPACE_THR);
    localparam logic [c_CNT_W-1:0] c_MARK_MIN       = c_CNT_W'(MARK_MIN);
    localparam logic [c_CNT_W-1:0] c_MARK_MAX       = c_CNT_W'(MARK_MAX);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LEAD_MARK  = 3'd1,
        S_LEAD_SPACE = 3'd2,
        S_BIT_MARK   = 3'd3,
        S_BIT_SPACE  = 3'd4,
        S_TRAIL_MARK = 3'd5,
        S_REP_MARK   = 3'd6
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizer and edge detect. Reset to the idle (high) level
    // so that leaving reset never fakes a mark start.
    // ------------------------------------------------------------------
    logic r_sync1, r_sync2, r_prev;
    logic w_fall, w_rise, w_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= ir_rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_fall = r_prev & ~r_sync2;
    assign w_rise = ~r_prev & r_sync2;
    assign w_edge = w_fall | w_rise;

    // ------------------------------------------------------------------
    // Microsecond timebase. The us counter measures the current phase
    // (restarts at every line edge) and parks one past the timeout so a
    // stuck line is seen as a timeout indefinitely.
    // ------------------------------------------------------------------
    logic [c_PRE_W-1:0] r_pre;
    logic [c_CNT_W-1:0] r_us_cnt;
    logic               w_tick;

    assign w_tick = (r_pre == c_PRE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre    <= '0;
            r_us_cnt <= '0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
            if (w_edge)
                r_us_cnt <= '0;
            else if (w_tick && (r_us_cnt != c_CNT_SAT))
                r_us_cnt <= r_us_cnt + 1'b1;
        end
    end

    logic w_timeout, w_mark_ok;
    assign w_timeout = (r_us_cnt > c_TIMEOUT);
    assign w_mark_ok = (r_us_cnt >= c_MARK_MIN) && (r_us_cnt <= c_MARK_MAX);

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t      r_state, w_state_nxt;
    logic [4:0]  r_bit_cnt, w_bit_cnt_nxt;
    logic [31:0] r_shift, w_shift_nxt;
    logic [31:0] w_cmd_nxt;
    logic        r_have_frame, w_have_nxt;
    logic        w_ready_nxt, w_repeat_nxt, w_error_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_have_frame  <= 1'b0;
            ir_command    <= '0;
            ir_data_ready <= 1'b0;
            ir_repeat     <= 1'b0;
            ir_error      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_bit_cnt     <= w_bit_cnt_nxt;
            r_shift       <= w_shift_nxt;
            r_have_frame  <= w_have_nxt;
            ir_command    <= w_cmd_nxt;
            ir_data_ready <= w_ready_nxt;
            ir_repeat     <= w_repeat_nxt;
            ir_error      <= w_error_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_cmd_nxt     = ir_command;
        w_have_nxt    = r_have_frame;
        w_ready_nxt   = 1'b0;
        w_repeat_nxt  = 1'b0;
        w_error_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_fall)
                    w_state_nxt = S_LEAD_MARK;
            end

            // Line stuck low or a short glitch is noise, not a frame error.
            S_LEAD_MARK: begin
                if (w_timeout)
                    w_state_nxt = S_IDLE;
                else if (w_rise)
                    w_state_nxt = (r_us_cnt >= c_LEAD_MARK_MIN) ? S_LEAD_SPACE : S_IDLE;
            end

            S_LEAD_SPACE: begin
                if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                    w_error_nxt = 1'b1;
                end else if (w_fall) begin
                    if (r_us_cnt >= c_LEAD_SPACE_THR) begin
                        w_state_nxt   = S_BIT_MARK;
                        w_bit_cnt_nxt = '0;
                    end else begin
                        w_state_nxt = S_REP_MARK;
                    end
                end
            end

            S_BIT_MARK: begin
                if (w_timeout || (w_rise && !w_mark_ok)) begin
                    w_state_nxt = S_IDLE;
                    w_error_nxt = 1'b1;
                end else if (w_rise) begin
                    w_state_nxt = S_BIT_SPACE;
                end
            end

            // Bit value is the length of the space that ends at this fall.
            S_BIT_SPACE: begin
                if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                    w_error_nxt = 1'b1;
                end else if (w_fall) begin
                    w_shift_nxt[r_bit_cnt] = (r_us_cnt >= c_BIT_SPACE_THR);
                    if (r_bit_cnt == 5'd31) begin
                        w_state_nxt = S_TRAIL_MARK;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                        w_state_nxt   = S_BIT_MARK;
                    end
                end
            end

            S_TRAIL_MARK: begin
                if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                    w_error_nxt = 1'b1;
                end else if (w_rise) begin
                    w_state_nxt = S_IDLE;
`ifdef IR_CMD_CHECK_EN
                    if (r_shift[31:24] == ~r_shift[23:16]) begin
                        w_cmd_nxt   = r_shift;
                        w_have_nxt  = 1'b1;
                        w_ready_nxt = 1'b1;
                    end else begin
                        w_error_nxt = 1'b1;
                    end
`else
                    w_cmd_nxt   = r_shift;
                    w_have_nxt  = 1'b1;
                    w_ready_nxt = 1'b1;
`endif
                end
            end

            // A repeat is only meaningful once there is a command to repeat.
            S_REP_MARK: begin
                if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                    w_error_nxt = 1'b1;
                end else if (w_rise) begin
                    w_state_nxt = S_IDLE;
                    if (r_have_frame && w_mark_ok)
                        w_repeat_nxt = 1'b1;
                    else
                        w_error_nxt = 1'b1;
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire
